bcd_display_counter: RTL and testbench
======================================

Name: bcd_display_counter

Overview:
- Parametrised successor to the 8-bit counter / combinational binary-to-BCD pair.
- Binary up/down counter with preload, wrap flag, and an iterative (double-dabble) BCD converter.
- The converter has a busy/valid handshake and replaces the wide combinational decoder.
- Output drives the multi-digit 7-segment display path.

Parameters:
- WIDTH, 8, counter width in bits.
- DIGITS, 3, BCD digits on the output. Elaboration error unless 10**DIGITS > 2**WIDTH-1.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous reset, active-low (rst==0 resets at the next clk edge).
- en  input  1  count enable.
- ld  input  1  preload strobe.
- up  input  1  direction: 1 increments, 0 decrements.
- v  input  WIDTH  preload value.
- count  output  WIDTH  current binary count.
- ovf  output  1  one-cycle pulse on a wrap.
- bcd  output  4*DIGITS  packed BCD; digit 0 is in bits [3:0].
- bcd_valid  output  1  one-cycle pulse when bcd updates.
- busy  output  1  converter is running.

Behaviour:
- Reset (rst==0 at an edge):
  - count=0, ovf=0, bcd=0, bcd_valid=0, busy=0.
  - FSM returns to IDLE and the last-converted register is cleared to 0.
  - A conversion in progress is aborted with no bcd_valid.
- Counter priority: rst > ld > en.
  - ld=1: count<=v, ovf=0.
  - en=1, up=1: count<=count+1. At 2**WIDTH-1 it wraps to 0 and ovf=1 that cycle.
  - en=1, up=0: count<=count-1. At 0 it wraps to 2**WIDTH-1 and ovf=1.
  - Otherwise count holds and ovf=0.
- ovf is registered and is high only in the cycle after the wrapping edge.
- Converter FSM, states IDLE, SHIFT, DONE:
  - IDLE: if count != last_converted, snapshot count into a shift register, clear the BCD scratch, set iteration counter=0, busy=1, go to SHIFT. Otherwise stay in IDLE with busy=0.
  - SHIFT (one iteration per cycle, exactly WIDTH cycles): add 3 to every scratch digit >=5, then shift {scratch,snapshot} left by 1. After iteration WIDTH-1, go to DONE.
  - DONE (1 cycle): bcd<=scratch, bcd_valid=1, last_converted<=snapshot, busy=0, go to IDLE.
- Latency: count changes at edge k.
  - Snapshot is taken at edge k+1.
  - bcd/bcd_valid update at edge k+WIDTH+2.
  - busy is high for WIDTH+1 cycles.
- count changing during SHIFT does not disturb the snapshot. On returning to IDLE the FSM sees the mismatch and restarts.
- Consequences:
  - bcd always equals the decimal of some value count previously held.
  - bcd equals the current count within 2*(WIDTH+2) cycles of count going stable.
- bcd and last_converted hold between conversions.
- No conversion is triggered when count is reloaded with its current value.

Test Plan:
- Reset, then ld=1 with v=8'd255 for one cycle, en=0 -> count=255 next cycle. busy high 9 cycles, then bcd=12'h255 with a single bcd_valid pulse 10 cycles after the load edge.
- ld v=254, then en=1 up=1 for 2 cycles -> count 255 then 0. ovf pulses once on the 255->0 wrap. bcd settles to 12'h000.
- ld v=0, then en=1 up=0 for 1 cycle -> count=255, ovf=1 for one cycle, bcd settles to 12'h255.
- en=1 up=1 continuously for 50 cycles from 0:
  - every bcd_valid value is the decimal of a count previously held;
  - after en drops at count=50, bcd=12'h050 within 20 cycles, then busy stays 0.
- ld=1 and en=1 in the same cycle with v=8'd42 -> count=42 (load wins), ovf=0.
- rst=0 for one cycle while busy=1 -> next cycle count=0, bcd=0, busy=0, no bcd_valid.
- Re-run with WIDTH=12, DIGITS=4: ld v=4095 -> bcd=16'h4095 after 14 cycles.

Source files
------------

// File: rtl/bcd_display_counter.sv
// Up/down counter with preload and wrap pulse, followed by an
// iterative double-dabble converter feeding the 7-segment path.
module bcd_display_counter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                ld,
  input  logic                up,
  input  logic [WIDTH-1:0]    v,
  output logic [WIDTH-1:0]    count,
  output logic                ovf,
  output logic [4*DIGITS-1:0] bcd,
  output logic                bcd_valid,
  output logic                busy
);

  localparam int BW = 4 * DIGITS;
  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
  localparam longint unsigned MAXV = (64'd1 << WIDTH) - 64'd1;
  localparam longint unsigned DECV = 64'd10 ** DIGITS;

  if (DECV <= MAXV) begin : g_bad_digits
    $error("DIGITS too small to hold 2**WIDTH-1");
  end

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t          r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic [WIDTH-1:0] r_snap;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_last;
  logic [BW-1:0]    r_scr;
  logic [BW-1:0]    r_bcd;
  logic [IW-1:0]    r_iter;
  logic             r_valid;
  logic             r_busy;
  logic [BW-1:0]    w_adj;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (ld) begin
      r_count <= v;
      r_ovf   <= 1'b0;
    end else if (en && up) begin
      r_count <= r_count + WIDTH'(1);
      r_ovf   <= (r_count == '1);
    end else if (en) begin
      r_count <= r_count - WIDTH'(1);
      r_ovf   <= (r_count == '0);
    end else begin
      r_ovf   <= 1'b0;
    end
  end

  // add-3 correction applied to every digit before each shift
  always_comb begin
    w_adj = r_scr;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_scr[4*d +: 4] >= 4'd5)
        w_adj[4*d +: 4] = r_scr[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_snap  <= '0;
      r_shift <= '0;
      r_last  <= '0;
      r_scr   <= '0;
      r_bcd   <= '0;
      r_iter  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (r_count != r_last) begin
            r_snap  <= r_count;
            r_shift <= r_count;
            r_scr   <= '0;
            r_iter  <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        SHIFT: begin
          r_scr   <= {w_adj[BW-2:0], r_shift[WIDTH-1]};
          r_shift <= {r_shift[WIDTH-2:0], 1'b0};
          r_iter  <= r_iter + IW'(1);
          if (r_iter == LAST)
            r_state <= DONE;
        end
        DONE: begin
          r_bcd   <= r_scr;
          r_valid <= 1'b1;
          r_last  <= r_snap;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign count     = r_count;
  assign ovf       = r_ovf;
  assign bcd       = r_bcd;
  assign bcd_valid = r_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_bcd_display_counter.sv
// Directed bench for bcd_display_counter: counter, wrap pulse,
// conversion latency, history of converted values, reset abort.
module tb_bcd_display_counter;

  logic        clk = 1'b0;
  logic        rst, en, ld, up;
  logic [7:0]  v;
  logic [7:0]  count;
  logic        ovf, bcd_valid, busy;
  logic [11:0] bcd;

  logic        rst12, en12, ld12, up12;
  logic [11:0] v12;
  logic [11:0] count12;
  logic        ovf12, valid12, busy12;
  logic [15:0] bcd12;

  int n_cmp = 0;
  int n_bad = 0;
  int nvalid = 0;
  int novf = 0;
  bit seen [256];

  always #5 clk = ~clk;

  bcd_display_counter #(.WIDTH(8), .DIGITS(3)) u8 (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .up(up), .v(v),
    .count(count), .ovf(ovf), .bcd(bcd),
    .bcd_valid(bcd_valid), .busy(busy)
  );

  bcd_display_counter #(.WIDTH(12), .DIGITS(4)) u12 (
    .clk(clk), .rst(rst12), .en(en12), .ld(ld12), .up(up12),
    .v(v12), .count(count12), .ovf(ovf12), .bcd(bcd12),
    .bcd_valid(valid12), .busy(busy12)
  );

  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock, sampled 1 time unit after the rising edge
  task automatic tick();
    bit found;
    @(posedge clk);
    #1;
    seen[count] = 1'b1;
    if (ovf) novf++;
    if (bcd_valid) begin
      nvalid++;
      found = 1'b0;
      for (int i = 0; i < 256; i++)
        if (seen[i] && to_bcd(i) == bcd) found = 1'b1;
      check("hist", 32'(found), 32'd1);
    end
  endtask

  task automatic settle(input string tag, input logic [11:0] exp,
                        input int budget);
    int k;
    k = 0;
    while (!(bcd == exp && !busy) && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(bcd), 32'(exp));
  endtask

  initial begin
    int bc, nv0, no0;
    rst = 1'b0; en = 1'b0; ld = 1'b0; up = 1'b1; v = '0;
    rst12 = 1'b0; en12 = 1'b0; ld12 = 1'b0; up12 = 1'b1; v12 = '0;
    tick();
    tick();
    rst = 1'b1;
    rst12 = 1'b1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_valid", 32'(bcd_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // load 255, watch latency
    ld = 1'b1; v = 8'd255;
    tick();
    ld = 1'b0;
    check("ld255_count", 32'(count), 32'd255);
    check("ld255_busy0", 32'(busy), 32'd0);
    bc = 0;
    nv0 = nvalid;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy) bc++;
    end
    check("busy_cycles", 32'(bc), 32'd9);
    check("lat_valid", 32'(bcd_valid), 32'd1);
    check("lat_bcd", 32'(bcd), 32'h255);
    check("one_pulse", 32'(nvalid - nv0), 32'd1);
    tick();
    check("valid_drop", 32'(bcd_valid), 32'd0);

    // up-wrap 255 -> 0
    no0 = novf;
    ld = 1'b1; v = 8'd254;
    tick();
    ld = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    check("up_255", 32'(count), 32'd255);
    check("up_ovf0", 32'(ovf), 32'd0);
    tick();
    en = 1'b0;
    check("wrap_0", 32'(count), 32'd0);
    check("wrap_ovf", 32'(ovf), 32'd1);
    tick();
    check("wrap_ovf_drop", 32'(ovf), 32'd0);
    check("ovf_once", 32'(novf - no0), 32'd1);
    settle("wrap_bcd", 12'h000, 40);

    // down-wrap 0 -> 255
    ld = 1'b1; v = 8'd0;
    tick();
    ld = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    en = 1'b0;
    check("dn_255", 32'(count), 32'd255);
    check("dn_ovf", 32'(ovf), 32'd1);
    tick();
    check("dn_ovf_drop", 32'(ovf), 32'd0);
    settle("dn_bcd", 12'h255, 40);

    // reload with current value starts nothing
    ld = 1'b1; v = 8'd255;
    tick();
    ld = 1'b0;
    nv0 = nvalid;
    bc = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy) bc++;
    end
    check("same_ld_busy", 32'(bc), 32'd0);
    check("same_ld_valid", 32'(nvalid - nv0), 32'd0);

    // free run 0..50
    ld = 1'b1; v = 8'd0;
    tick();
    ld = 1'b0;
    settle("run_start", 12'h000, 40);
    nv0 = nvalid;
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    en = 1'b0;
    check("run_count", 32'(count), 32'd50);
    check("run_pulses", 32'(nvalid - nv0 > 0), 32'd1);
    settle("run_bcd", 12'h050, 20);
    bc = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy) bc++;
    end
    check("run_quiet", 32'(bc), 32'd0);

    // load beats enable
    ld = 1'b1; v = 8'd255;
    tick();
    en = 1'b1; up = 1'b1; v = 8'd42;
    tick();
    ld = 1'b0; en = 1'b0;
    check("ld_wins", 32'(count), 32'd42);
    check("ld_no_ovf", 32'(ovf), 32'd0);

    // reset aborts a running conversion
    tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    nv0 = nvalid;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("ab_count", 32'(count), 32'd0);
    check("ab_bcd", 32'(bcd), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_valid", 32'(bcd_valid), 32'd0);
    for (int i = 0; i < 12; i++) tick();
    check("ab_no_pulse", 32'(nvalid - nv0), 32'd0);
    check("ab_bcd_hold", 32'(bcd), 32'd0);

    // 12-bit instance
    ld12 = 1'b1; v12 = 12'd4095;
    tick();
    ld12 = 1'b0;
    check("w12_count", 32'(count12), 32'd4095);
    bc = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (valid12) bc++;
    end
    check("w12_early", 32'(bc), 32'd0);
    tick();
    check("w12_valid", 32'(valid12), 32'd1);
    check("w12_bcd", 32'(bcd12), 32'h4095);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
